// File: rtl/mem_responder_if.sv
// Native memory bus between the core (master) and a memory slave.
// The core drives the request fields and holds them until it samples mem_ready;
// the slave answers with a one-cycle mem_ready strobe plus read data and error flag.
interface mem_responder_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata, mem_err
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata, mem_err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder for the core's native memory bus.
// Each request is latched in IDLE, waits IWAIT/DWAIT cycles (frozen while hold
// is high), is executed on the edge entering RESP and answered with a one-cycle
// mem_ready pulse. Bad accesses are answered with mem_err; initiator handshake
// violations set the sticky proto_viol flag without affecting the transaction.
module mem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int IWAIT      = 0,
   parameter int DWAIT      = 1
) (
   input  logic             clk,
   input  logic             reset,
   mem_responder_if.slave   bus,
   input  logic             hold,
   output logic             proto_viol
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        instr_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic        ready_r;
   logic [31:0] rdata_r;
   logic        err_r;
   logic        proto_viol_r;

   // Word storage; deliberately not reset so it maps onto plain RAM.
   logic [31:0] mem_r [DEPTH];

   logic [DEPTH_LOG2-1:0] word_idx_s;
   logic                  err_s;
   logic                  access_s;
   logic                  we_s;
   logic                  mismatch_s;

   // A request is rejected when misaligned, beyond the array, or a fetch that writes.
   function automatic logic access_error(input logic [31:0] addr,
                                         input logic        instr,
                                         input logic [3:0]  wstrb);
      logic misaligned;
      logic out_of_range;
      logic fetch_write;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
      fetch_write  = instr && (wstrb != 4'b0000);
      return misaligned || out_of_range || fetch_write;
   endfunction

   assign word_idx_s = addr_r[DEPTH_LOG2+1:2];
   assign err_s      = access_error(addr_r, instr_r, wstrb_r);
   // The access happens on the edge that leaves WAIT for RESP.
   assign access_s   = (state_r == ST_WAIT) && !hold && (cnt_r == 4'd0);
   assign we_s       = access_s && !err_s && (wstrb_r != 4'b0000);
   assign mismatch_s = !bus.mem_valid
                     || (bus.mem_addr  != addr_r)
                     || (bus.mem_wdata != wdata_r)
                     || (bus.mem_wstrb != wstrb_r)
                     || (bus.mem_instr != instr_r);

   assign bus.mem_ready = ready_r;
   assign bus.mem_rdata = rdata_r;
   assign bus.mem_err   = err_r;
   assign proto_viol    = proto_viol_r;

   // Byte-lane writes into the array; a reset on the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (!reset && we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_r[i]) begin
               mem_r[word_idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
            end
         end
      end
   end

   // Transaction FSM with registered response outputs and the sticky protocol checker.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         instr_r      <= 1'b0;
         addr_r       <= 32'd0;
         wdata_r      <= 32'd0;
         wstrb_r      <= 4'b0000;
         ready_r      <= 1'b0;
         rdata_r      <= 32'd0;
         err_r        <= 1'b0;
         proto_viol_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ready_r <= 1'b0;
               rdata_r <= 32'd0;
               err_r   <= 1'b0;
               if (bus.mem_valid) begin
                  instr_r <= bus.mem_instr;
                  addr_r  <= bus.mem_addr;
                  wdata_r <= bus.mem_wdata;
                  wstrb_r <= bus.mem_wstrb;
                  cnt_r   <= bus.mem_instr ? 4'(IWAIT) : 4'(DWAIT);
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (hold) begin
                  cnt_r <= cnt_r;
               end else if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  ready_r <= 1'b1;
                  err_r   <= err_s;
                  rdata_r <= (err_s || (wstrb_r != 4'b0000)) ? 32'd0 : mem_r[word_idx_s];
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: begin
               ready_r <= 1'b0;
               rdata_r <= 32'd0;
               err_r   <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               rdata_r <= 32'd0;
               err_r   <= 1'b0;
               cnt_r   <= 4'd0;
               state_r <= ST_IDLE;
            end
         endcase

         // Initiator must hold a stable request from acceptance through the response cycle.
         if (((state_r == ST_WAIT) || (state_r == ST_RESP)) && mismatch_s) begin
            proto_viol_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: expected responses are queued when a
// request is issued and compared when mem_ready arrives.
module tb_mem_responder;
   localparam int DEPTH_LOG2 = 10;
   localparam int IWAIT      = 0;
   localparam int DWAIT      = 1;

   logic clk = 1'b0;
   logic reset;
   logic hold;
   logic proto_viol;

   mem_responder_if bus();

   mem_responder #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .IWAIT      (IWAIT),
      .DWAIT      (DWAIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .hold       (hold),
      .proto_viol (proto_viol)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model [int];
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request; viol=1 drops mem_valid, viol=2 perturbs mem_addr in the first WAIT cycle.
   task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int hold_n, input int viol);
      exp_t        e;
      exp_t        got_e;
      int          k;
      int          hn;
      int          word;
      logic        got;
      logic [31:0] old;
      word  = int'(addr >> 2);
      e.err = (addr[1:0] != 2'b00) || ((addr >> 2) >= (32'd1 << DEPTH_LOG2))
              || (instr && (wstrb != 4'b0000));
      e.lat = 1 + (instr ? IWAIT : DWAIT) + hold_n;
      if (e.err) begin
         e.rdata = 32'd0;
      end else if (wstrb == 4'b0000) begin
         e.rdata = model[word];
      end else begin
         old = model.exists(word) ? model[word] : 32'd0;
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) old[8*i +: 8] = wdata[8*i +: 8];
         end
         model[word] = old;
         e.rdata = 32'd0;
      end
      sb_q.push_back(e);

      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_instr = instr;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_wstrb = wstrb;
      k   = 0;
      got = 1'b0;
      hn  = hold_n;
      while (!got && k < 64) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.mem_ready === 1'b1) begin
            got = 1'b1;
         end else begin
            hold = (hn > 0);
            if (hn > 0) hn--;
            if (k == 1) begin
               if (viol == 1) bus.mem_valid = 1'b0;
               if (viol == 2) bus.mem_addr = addr ^ 32'h0000_0004;
            end else if (k == 2) begin
               bus.mem_valid = 1'b1;
               bus.mem_addr  = addr;
            end
         end
      end
      hold = 1'b0;
      check("ready_seen", {31'd0, got}, 32'd1);
      got_e = sb_q.pop_front();
      if (got) begin
         check("rdata", bus.mem_rdata, got_e.rdata);
         check("err", {31'd0, bus.mem_err}, {31'd0, got_e.err});
         check("latency", 32'(k - 1), 32'(got_e.lat));
         @(posedge clk);
         #1;
         check("ready_pulse", {31'd0, bus.mem_ready}, 32'd0);
         check("rdata_idle", bus.mem_rdata, 32'd0);
      end
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'b0000;
   endtask

   initial begin
      reset         = 1'b1;
      hold          = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_instr = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      bus.mem_wstrb = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
      check("rst_rdata", bus.mem_rdata, 32'd0);
      check("rst_err", {31'd0, bus.mem_err}, 32'd0);
      check("rst_proto", {31'd0, proto_viol}, 32'd0);
      reset = 1'b0;

      // Full write, read back, then byte-lane merge.
      do_req(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 0);
      do_req(1'b0, 32'h10, 32'h000000AA, 4'h1, 0, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 0);

      // Instruction fetch with zero wait, then a stalled data read.
      do_req(1'b0, 32'h0, 32'h12345678, 4'hF, 0, 0);
      do_req(1'b1, 32'h0, 32'h0, 4'h0, 0, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 3, 0);

      // Error cases; the rejected fetch-write must leave word 0 unchanged.
      do_req(1'b0, 32'h12, 32'h0, 4'h0, 0, 0);
      do_req(1'b0, 32'h1000, 32'h0, 4'h0, 0, 0);
      do_req(1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, 0, 0);
      do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, 0);
      do_req(1'b0, 32'hFFC, 32'h0BADF00D, 4'hF, 0, 0);
      do_req(1'b0, 32'hFFC, 32'h0, 4'h0, 0, 0);

      // Random full and partial writes over a small window, then read back.
      for (int i = 0; i < 8; i++) do_req(1'b0, 32'h40 + 32'(4 * i), $urandom, 4'hF, 0, 0);
      for (int i = 0; i < 8; i++) do_req(1'b0, 32'h40 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), 0, 0);
      for (int i = 0; i < 8; i++) do_req(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, 0, 0);
      check("proto_legal", {31'd0, proto_viol}, 32'd0);

      // Reset in the WAIT cycle of a write drops it.
      do_req(1'b0, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0);
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_instr = 1'b0;
      bus.mem_addr  = 32'h20;
      bus.mem_wdata = 32'h11111111;
      bus.mem_wstrb = 4'hF;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("wrst_ready", {31'd0, bus.mem_ready}, 32'd0);
      check("wrst_rdata", bus.mem_rdata, 32'd0);
      check("wrst_err", {31'd0, bus.mem_err}, 32'd0);
      check("wrst_proto", {31'd0, proto_viol}, 32'd0);
      reset         = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("wrst_no_ready", {31'd0, bus.mem_ready}, 32'd0);
      end
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 0);

      // Dropped mem_valid sets the sticky flag; it survives a legal transaction.
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1);
      check("proto_drop", {31'd0, proto_viol}, 32'd1);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 0);
      check("proto_sticky", {31'd0, proto_viol}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("proto_cleared", {31'd0, proto_viol}, 32'd0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 2);
      check("proto_addr", {31'd0, proto_viol}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
